// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with a memory handshake.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_src_jump,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        reg_dst,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_SW   = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000101;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_FUNCT = 2'd1;
  localparam logic [1:0] ALU_CMP   = 2'd2;

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       illegal_q, illegal_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: state_d = S_EXEC;
          OP_HLT:  state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:  state_d = S_MEM;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ready) state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default: begin
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase
  end

  // Reset forces every output low, including the displayed state.
  always_comb begin
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src_jump   = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 1'b0;
    reg_dst       = 1'b0;
    alu_src       = 1'b0;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    halted        = 1'b0;
    illegal       = 1'b0;
    state         = 3'd0;
    if (!rst) begin
      state   = state_q;
      illegal = illegal_q;
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_R: alu_op = ALU_FUNCT;
            OP_ADDI, OP_LW, OP_SW: alu_src = 1'b1;
            OP_BEQ: begin
              alu_op        = ALU_CMP;
              pc_write_cond = 1'b1;
              instr_done    = 1'b1;
            end
            OP_J: begin
              pc_write    = 1'b1;
              pc_src_jump = 1'b1;
              instr_done  = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_read  = (op_q == OP_LW);
          mem_write = (op_q == OP_SW);
          if (mem_ready && op_q == OP_SW) instr_done = 1'b1;
        end
        S_WB: begin
          reg_write  = 1'b1;
          wb_sel     = (op_q == OP_LW);
          reg_dst    = (op_q == OP_R);
          instr_done = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_q, instr_q;

  // Both counters wrap naturally at 32 bits; HALT cycles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state_q != S_HALT) cycle_q <= cycle_q + 32'd1;
      if (instr_done)        instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_cnt = rst ? 32'd0 : cycle_q;
  assign instr_cnt = rst ? 32'd0 : instr_q;
`else
  assign cycle_cnt = 32'd0;
  assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: random instruction stream with random memory waits,
// followed by directed reset, illegal-opcode, HLT/counter and aborted-store sequences.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_read, mem_write, ir_write, pc_write, pc_write_cond;
  logic        pc_src_jump, reg_write, wb_sel, reg_dst, alu_src;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic        instr_done, halted, illegal;
  logic [31:0] cycle_cnt, instr_cnt;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src_jump(pc_src_jump), .reg_write(reg_write), .wb_sel(wb_sel),
    .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op), .state(state),
    .instr_done(instr_done), .halted(halted), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

`ifdef MULTICYCLE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] OP_R = 6'd0, OP_ADDI = 6'd1, OP_LW = 6'd2, OP_SW = 6'd3;
  localparam logic [5:0] OP_BEQ = 6'd4, OP_J = 6'd5, OP_HLT = 6'd63, OP_BAD = 6'b101010;
  localparam int N_INSTR = 150;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response of one retired instruction.
  typedef struct {
    logic [5:0]  op;
    int          lat;
    logic [11:0] ctl;
  } exp_t;

  exp_t exp_q[$];

  // Control outputs in the retiring cycle:
  // {ir_write, reg_write, wb_sel, reg_dst, pc_write_cond, pc_write, pc_src_jump,
  //  mem_write, mem_read, mem_req, alu_op[1:0]}
  function automatic logic [11:0] done_ctl(input logic [5:0] op);
    case (op)
      OP_R:    return 12'b0101_0000_0000;
      OP_ADDI: return 12'b0100_0000_0000;
      OP_LW:   return 12'b0110_0000_0000;
      OP_SW:   return 12'b0000_0001_0100;
      OP_BEQ:  return 12'b0000_1000_0010;
      default: return 12'b0000_0110_0000;
    endcase
  endfunction

  function automatic int base_lat(input logic [5:0] op);
    case (op)
      OP_R, OP_ADDI, OP_SW: return 4;
      OP_LW:                return 5;
      default:              return 3;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every instr_done and checks latency and controls.
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   tot = 0;
  int   dones = 0;
  logic prev_hold = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hold) check("mem_req_held", mem_req, 1'b1);
      if (instr_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got instr_done=1 expected no retirement at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("latency_op%0d", e.op), cyc + 1, e.lat);
          check($sformatf("done_ctl_op%0d", e.op),
                {ir_write, reg_write, wb_sel, reg_dst, pc_write_cond, pc_write, pc_src_jump,
                 mem_write, mem_read, mem_req, alu_op}, e.ctl);
        end
        check("instr_cnt", instr_cnt, PERF ? dones : 0);
        check("cycle_cnt", cycle_cnt, PERF ? tot : 0);
        dones++;
        cyc = 0;
      end else begin
        cyc++;
      end
      prev_hold = mem_req && !mem_ready;
      tot++;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic cyc_in(input logic rdy, input logic [5:0] op);
    mem_ready = rdy;
    opcode    = op;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [5:0] ops [6];

  initial begin
    int issued = 0, left = 0, wcnt = 0, mw = 0, guard = 0;
    bit stop = 1'b0;
    ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};

    // Reset holds every output low even with mem_ready asserted.
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    #1;
    check("rst_state", state, 3'd0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_ir_write", ir_write, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_instr_cnt", instr_cnt, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("post_rst_state", state, 3'd0);
    check("post_rst_mem_req", mem_req, 1'b1);

    // Random stream: each memory access waits a random number of cycles.
    while (!stop) begin
      if (mem_req) begin
        if (left == 0 && issued == N_INSTR) begin
          mem_ready = 1'b0;
          stop = 1'b1;
        end else begin
          if (left == 0) begin
            exp_t e;
            logic [5:0] op;
            int fw;
            op   = ops[$urandom_range(0, 5)];
            fw   = $urandom_range(0, 3);
            mw   = (op == OP_LW || op == OP_SW) ? $urandom_range(0, 3) : 0;
            left = (op == OP_LW || op == OP_SW) ? 2 : 1;
            wcnt = fw;
            opcode = op;
            e.op  = op;
            e.lat = base_lat(op) + fw + mw;
            e.ctl = done_ctl(op);
            exp_q.push_back(e);
            issued++;
          end
          if (wcnt > 0) begin
            mem_ready = 1'b0;
            wcnt--;
          end else begin
            mem_ready = 1'b1;
            left--;
            wcnt = mw;
          end
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (!stop) begin
        @(posedge clk);
        #1;
        guard++;
        if (guard > 20000) begin
          checks++;
          errors++;
          $display("FAIL stream_timeout: got %0d issued expected %0d within budget", issued, N_INSTR);
          stop = 1'b1;
        end
      end
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("retired_count", dones, N_INSTR);
    mon_en = 1'b0;

    // Illegal opcode: HALT with illegal set, no retirement, sticky until reset.
    do_reset();
    cyc_in(1'b1, OP_BAD); check("ill_fetch_state", state, 3'd0);
    tick(); cyc_in(1'b0, OP_BAD); check("ill_decode_state", state, 3'd1);
    tick(); cyc_in(1'b1, OP_BAD);
    check("ill_state", state, 3'd5);
    check("ill_halted", halted, 1'b1);
    check("ill_illegal", illegal, 1'b1);
    check("ill_mem_req", mem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); cyc_in(1'($urandom_range(0, 1)), OP_R);
      check("ill_stay_halted", halted, 1'b1);
      check("ill_stay_illegal", illegal, 1'b1);
      check("ill_no_done", instr_done, 1'b0);
    end
    tick(); rst = 1'b1; #1;
    check("ill_rst_forced", illegal, 1'b0);
    tick(); rst = 1'b0; #1;
    check("ill_cleared", illegal, 1'b0);
    check("ill_cleared_state", state, 3'd0);

    // Five R instructions then HLT: counters freeze in HALT.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc_in(1'b1, OP_R); check("r_fetch", {state, ir_write, pc_write}, {3'd0, 2'b11});
      tick(); cyc_in(1'b0, OP_R); check("r_decode", state, 3'd1);
      tick(); cyc_in(1'b0, OP_R);
      check("r_exec", {state, alu_op, alu_src, instr_done}, {3'd2, 2'd1, 2'b00});
      tick(); cyc_in(1'b0, OP_R);
      check("r_wb", {state, reg_write, reg_dst, instr_done}, {3'd4, 3'b111});
      tick();
    end
    cyc_in(1'b1, OP_HLT);
    tick(); cyc_in(1'b0, OP_HLT); check("hlt_decode", state, 3'd1);
    tick(); cyc_in(1'b1, OP_R);
    check("hlt_halted", {state, halted, illegal, instr_done}, {3'd5, 3'b100});
    check("hlt_instr_cnt", instr_cnt, PERF ? 5 : 0);
    check("hlt_cycle_cnt", cycle_cnt, PERF ? 22 : 0);
    repeat (3) tick();
    cyc_in(1'b0, OP_R);
    check("hlt_cycle_frozen", cycle_cnt, PERF ? 22 : 0);
    check("hlt_still_halted", state, 3'd5);

    // Reset during a store wait abandons the access.
    do_reset();
    cyc_in(1'b1, OP_SW);
    tick(); cyc_in(1'b0, OP_SW);
    tick(); cyc_in(1'b0, OP_SW); check("sw_exec", {state, alu_src}, {3'd2, 1'b1});
    tick(); cyc_in(1'b0, OP_SW);
    check("sw_mem", {state, mem_req, mem_write, mem_read, instr_done}, {3'd3, 4'b1100});
    tick(); cyc_in(1'b0, OP_SW); check("sw_mem_wait", state, 3'd3);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("sw_rst_forced", {state, mem_req, mem_write, instr_done}, {3'd0, 3'b000});
    tick(); rst = 1'b0; mem_ready = 1'b0; #1;
    check("sw_after_rst", {state, mem_req, mem_write, instr_done, reg_write}, {3'd0, 4'b1000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 opcode  input  6  instruction opcode (IR[31:26]), valid from DECODE onward.
REQ-003 mem_ready  input  1  memory completion strobe, sampled only while mem_req=1.
REQ-004 mem_req  output  1  memory access request; held high until mem_ready.
REQ-005 mem_read / mem_write  output  1 each  access direction, qualified by mem_req.
REQ-006 ir_write, pc_write, pc_write_cond, pc_src_jump, reg_write, wb_sel, reg_dst, alu_src  output  1 each  datapath enables/selects.
REQ-007 alu_op  output  2  ALU_control operation class: 0=add, 1=funct passthrough, 2=compare (0001).
REQ-008 state  output  3  current state; instr_done  output  1; halted  output  1; illegal  output  1.
REQ-009 cycle_cnt, instr_cnt  output  32 each  performance counters (REQ-027).

Function
REQ-010 States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to HALT with illegal=1.
REQ-011 Opcodes: 000000 R, 000001 ADDI, 000010 LW, 000011 SW, 000100 BEQ, 000101 J, 111111 HLT; all others illegal.
REQ-012 Outputs SHALL be combinational functions of state, latched opcode (op_q) and mem_ready; unlisted outputs are 0.
REQ-013 FETCH: mem_req=1, mem_read=1; when mem_ready=1: ir_write=1, pc_write=1 (PC+4), next DECODE; otherwise remain in FETCH.
REQ-014 DECODE: op_q <= opcode; one cycle; illegal opcode -> HALT with illegal=1; HLT -> HALT with illegal=0; else -> EXEC.
REQ-015 EXEC R: alu_op=1, alu_src=0 -> WB. ADDI/LW/SW: alu_op=0, alu_src=1; ADDI -> WB, LW/SW -> MEM.
REQ-016 EXEC BEQ: alu_op=2, pc_write_cond=1, instr_done=1 -> FETCH. EXEC J: pc_write=1, pc_src_jump=1, instr_done=1 -> FETCH.
REQ-017 MEM: mem_req=1, mem_read=(op_q==LW), mem_write=(op_q==SW); stay until mem_ready; then LW -> WB, SW -> FETCH with instr_done=1.
REQ-018 WB: reg_write=1, wb_sel=(op_q==LW), reg_dst=(op_q==R), instr_done=1 -> FETCH.
REQ-019 HALT: all control outputs 0, halted=1; exit only via rst; illegal stays asserted while in HALT.
REQ-020 Zero-wait-state latency: R/ADDI 4 cycles, LW 5, SW 4, BEQ/J 3; each mem wait cycle adds one.
REQ-021 mem_ready when mem_req=0 SHALL be ignored; mem_req SHALL not drop before mem_ready.
REQ-022 instr_done SHALL be a single-cycle pulse in the final cycle of each retired instruction; never asserted for HLT or illegal.

Reset
REQ-023 rst=1 at a clock edge SHALL set state=FETCH, op_q=0, illegal=0, counters=0, regardless of current state or pending memory access.
REQ-024 While rst=1 all outputs SHALL be forced to 0 (state=0 shown); mem_ready SHALL be ignored.
REQ-025 First cycle after rst deasserts SHALL be FETCH with mem_req=1.
REQ-026 Reset mid-access SHALL abandon the access; no ir_write/reg_write for the aborted instruction.

Configuration
REQ-027 Macro MULTICYCLE_CTRL_PERF_EN: defined -> cycle_cnt increments every non-reset, non-HALT cycle, instr_cnt increments on each instr_done, both wrap 0xFFFFFFFF->0; undefined -> both ports present, tied to 0, no counter flops.

Verification
REQ-028 rst, then R opcode, mem_ready=1 always -> states 0,1,2,4,0; alu_op=1 in EXEC; reg_write, instr_done high in cycle 4 only.
REQ-029 LW with mem_ready delayed 3 cycles in FETCH and 2 in MEM -> 10 cycles total; mem_req steady high during waits; wb_sel=1 in WB.
REQ-030 BEQ then J -> 3 cycles each; pc_write_cond=1 with alu_op=2 for BEQ; pc_write=1, pc_src_jump=1 for J.
REQ-031 opcode 6'b101010 in DECODE -> HALT, halted=1, illegal=1, instr_done never; stays until rst; rst clears illegal.
REQ-032 rst asserted in MEM during SW wait -> next cycle state=0, mem_write=0, no instr_done.
REQ-033 PERF_EN defined, 5 R instructions then HLT -> instr_cnt=5, cycle_cnt=22 and frozen in HALT; undefined -> both read 0.
